// File: rtl/mcu_link_pkg.sv
// Shared types and command codes for the MCU SPI link router and its
// local interrupt controller.
package mcu_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE   = 2'd1,
        LOCAL   = 2'd2,
        DISCARD = 2'd3
    } link_state_e;

    typedef enum logic [1:0] {
        CMD  = 2'd0,
        ARG  = 2'd1,
        DONE = 2'd2
    } local_state_e;

    localparam logic [7:0] LOCAL_TARGET = 8'hFF;
    localparam logic [7:0] LCMD_RD_PEND = 8'h00;
    localparam logic [7:0] LCMD_WR_MASK = 8'h01;
    localparam logic [7:0] LCMD_RD_MASK = 8'h02;

endpackage

// File: rtl/mcu_irq_ctrl.sv
// Interrupt controller: rising-edge capture into pending, mask register,
// snapshot clear-on-read and a registered level irq to the MCU.
module mcu_irq_ctrl #(
    parameter int NTARGETS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NTARGETS-1:0] tgt_irq,
    input  logic                snap_en,
    input  logic                clr_en,
    input  logic                mask_we,
    input  logic [NTARGETS-1:0] mask_wdata,
    output logic [NTARGETS-1:0] pending,
    output logic [NTARGETS-1:0] mask,
    output logic                irq
);

    logic [NTARGETS-1:0] hist_r;
    logic [NTARGETS-1:0] pending_r;
    logic [NTARGETS-1:0] snap_r;
    logic [NTARGETS-1:0] mask_r;
    logic                irq_r;

    logic [NTARGETS-1:0] rise_s;
    logic [NTARGETS-1:0] clr_bits_s;
    logic [NTARGETS-1:0] pending_s;
    logic [NTARGETS-1:0] snap_s;
    logic [NTARGETS-1:0] mask_s;

    // Next-value logic; a new edge is OR-ed after the clear so set wins.
    always_comb begin
        rise_s     = tgt_irq & ~hist_r;
        clr_bits_s = clr_en ? snap_r : {NTARGETS{1'b0}};
        pending_s  = (pending_r & ~clr_bits_s) | rise_s;
        snap_s     = snap_en ? pending_r : snap_r;
        mask_s     = mask_we ? mask_wdata : mask_r;
    end

    // Interrupt state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r    <= {NTARGETS{1'b0}};
            pending_r <= {NTARGETS{1'b0}};
            snap_r    <= {NTARGETS{1'b0}};
            mask_r    <= {NTARGETS{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            hist_r    <= tgt_irq;
            pending_r <= pending_s;
            snap_r    <= snap_s;
            mask_r    <= mask_s;
            irq_r     <= |(pending_r & mask_r);
        end
    end

    assign pending = pending_r;
    assign mask    = mask_r;
    assign irq     = irq_r;

endmodule

// File: rtl/mcu_spi_router.sv
// Routes MCU SPI frames to a target selected by the first byte, muxes the
// target reply back, and serves local status/mask commands on address FF.
module mcu_spi_router
    import mcu_link_pkg::*;
#(
    parameter int NTARGETS  = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_in_strobe,
    input  logic                  data_in_start,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  irq,
    output logic [NTARGETS-1:0]   tgt_strobe,
    output logic                  tgt_start,
    output logic [7:0]            tgt_data,
    input  logic [8*NTARGETS-1:0] tgt_data_out,
    input  logic [NTARGETS-1:0]   tgt_irq
);

    localparam logic [7:0] NT_B = 8'(NTARGETS);

    link_state_e          state_r, state_s;
    local_state_e         lstate_r, lstate_s;
    logic [7:0]           sel_r, sel_s;
    logic [7:0]           cmd_r, cmd_s;
    logic                 first_pending_r, first_pending_s;
    logic [TIMEOUT_W-1:0] cnt_r, cnt_s;

    logic [7:0]           data_out_r, data_out_s;
    logic [NTARGETS-1:0]  tgt_strobe_r, tgt_strobe_s;
    logic                 tgt_start_r, tgt_start_s;
    logic [7:0]           tgt_data_r, tgt_data_s;

    logic                 strobe_start_s;
    logic                 strobe_data_s;
    logic [NTARGETS-1:0]  sel_onehot_s;
    logic [7:0]           reply_s;
    logic [7:0]           pend_byte_s;
    logic [7:0]           mask_byte_s;

    logic                 snap_en_s, clr_en_s, mask_we_s;
    logic [NTARGETS-1:0]  irq_pending_s, irq_mask_s;

    assign strobe_start_s = data_in_strobe & data_in_start;
    assign strobe_data_s  = data_in_strobe & ~data_in_start;
    assign pend_byte_s    = 8'(irq_pending_s);
    assign mask_byte_s    = 8'(irq_mask_s);

    // Target decode and reply mux; sel values outside the target range select nothing.
    always_comb begin
        reply_s = 8'h00;
        for (int i = 0; i < NTARGETS; i++) begin
            sel_onehot_s[i] = (sel_r == 8'(i));
            reply_s = reply_s | (tgt_data_out[8*i +: 8] & {8{sel_onehot_s[i]}});
        end
    end

    // Framing state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            lstate_r        <= CMD;
            sel_r           <= 8'h00;
            cmd_r           <= 8'h00;
            first_pending_r <= 1'b0;
            cnt_r           <= {TIMEOUT_W{1'b0}};
        end else begin
            state_r         <= state_s;
            lstate_r        <= lstate_s;
            sel_r           <= sel_s;
            cmd_r           <= cmd_s;
            first_pending_r <= first_pending_s;
            cnt_r           <= cnt_s;
        end
    end

    // Next-state logic: select bytes win over everything, then strobes, then timeout.
    always_comb begin
        state_s         = state_r;
        lstate_s        = lstate_r;
        sel_s           = sel_r;
        cmd_s           = cmd_r;
        first_pending_s = first_pending_r;
        cnt_s           = cnt_r;
        if (strobe_start_s) begin
            sel_s           = data_in;
            cnt_s           = {TIMEOUT_W{1'b0}};
            first_pending_s = 1'b0;
            lstate_s        = CMD;
            if (data_in < NT_B) begin
                state_s         = ROUTE;
                first_pending_s = 1'b1;
            end else if (data_in == LOCAL_TARGET) begin
                state_s = LOCAL;
            end else begin
                state_s = DISCARD;
            end
        end else if (state_r == IDLE) begin
            cnt_s = {TIMEOUT_W{1'b0}};
        end else if (data_in_strobe) begin
            cnt_s = {TIMEOUT_W{1'b0}};
            case (state_r)
                ROUTE: first_pending_s = 1'b0;
                LOCAL: begin
                    case (lstate_r)
                        CMD: begin
                            cmd_s = data_in;
                            if ((data_in == LCMD_RD_PEND) || (data_in == LCMD_WR_MASK)) begin
                                lstate_s = ARG;
                            end else begin
                                lstate_s = DONE;
                            end
                        end
                        ARG:     lstate_s = DONE;
                        DONE:    lstate_s = DONE;
                        default: lstate_s = DONE;
                    endcase
                end
                default: state_s = state_r;
            endcase
        end else if (cnt_r == {TIMEOUT_W{1'b1}}) begin
            state_s         = IDLE;
            first_pending_s = 1'b0;
            cnt_s           = {TIMEOUT_W{1'b0}};
        end else begin
            cnt_s = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
    end

    // Output and side-effect logic feeding the registered outputs and irq controller.
    always_comb begin
        data_out_s   = data_out_r;
        tgt_strobe_s = {NTARGETS{1'b0}};
        tgt_start_s  = 1'b0;
        tgt_data_s   = tgt_data_r;
        snap_en_s    = 1'b0;
        clr_en_s     = 1'b0;
        mask_we_s    = 1'b0;
        if (strobe_start_s) begin
            data_out_s = 8'h00;
        end else begin
            case (state_r)
                ROUTE: begin
                    data_out_s = reply_s;
                    if (strobe_data_s) begin
                        tgt_strobe_s = sel_onehot_s;
                        tgt_start_s  = first_pending_r;
                        tgt_data_s   = data_in;
                    end else begin
                        tgt_strobe_s = {NTARGETS{1'b0}};
                    end
                end
                LOCAL: begin
                    if (strobe_data_s) begin
                        case (lstate_r)
                            CMD: begin
                                case (data_in)
                                    LCMD_RD_PEND: begin
                                        data_out_s = pend_byte_s;
                                        snap_en_s  = 1'b1;
                                    end
                                    LCMD_RD_MASK: data_out_s = mask_byte_s;
                                    default:      data_out_s = 8'h00;
                                endcase
                            end
                            ARG: begin
                                clr_en_s  = (cmd_r == LCMD_RD_PEND);
                                mask_we_s = (cmd_r == LCMD_WR_MASK);
                            end
                            default: data_out_s = data_out_r;
                        endcase
                    end else begin
                        data_out_s = data_out_r;
                    end
                end
                default: data_out_s = 8'h00;
            endcase
        end
    end

    // Registered outputs toward MCU link and targets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r   <= 8'h00;
            tgt_strobe_r <= {NTARGETS{1'b0}};
            tgt_start_r  <= 1'b0;
            tgt_data_r   <= 8'h00;
        end else begin
            data_out_r   <= data_out_s;
            tgt_strobe_r <= tgt_strobe_s;
            tgt_start_r  <= tgt_start_s;
            tgt_data_r   <= tgt_data_s;
        end
    end

    mcu_irq_ctrl #(
        .NTARGETS (NTARGETS)
    ) u_irq_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .tgt_irq    (tgt_irq),
        .snap_en    (snap_en_s),
        .clr_en     (clr_en_s),
        .mask_we    (mask_we_s),
        .mask_wdata (data_in[NTARGETS-1:0]),
        .pending    (irq_pending_s),
        .mask       (irq_mask_s),
        .irq        (irq)
    );

    assign data_out   = data_out_r;
    assign tgt_strobe = tgt_strobe_r;
    assign tgt_start  = tgt_start_r;
    assign tgt_data   = tgt_data_r;

endmodule
